// File: rtl/bnn_sequencer.sv
// Control sequencer for the MNIST BNN: serial pixel load into an external buffer,
// XNOR-popcount scoring of every output neuron and a running argmax onto answer_o.
module bnn_sequencer #(
    parameter int N_PIX  = 784,
    parameter int N_NEUR = 10,
    parameter int AW     = 10,
    parameter int ACC_W  = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mode_i,
    input  logic          pixel_i,
    input  logic          weight_i,
    output logic          pix_we_o,
    output logic [AW-1:0] pix_addr_o,
    output logic          pix_wdata_o,
    input  logic          pix_rdata_i,
    output logic [3:0]    answer_o,
    output logic          valid_o,
    output logic          busy_o,
    output logic [1:0]    state_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        COMPUTE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [AW:0]   PCNT_FULL = (AW+1)'(N_PIX);
    localparam logic [AW-1:0] K_LAST    = AW'(N_PIX - 1);
    localparam logic [3:0]    N_LAST    = 4'(N_NEUR - 1);

    state_t           state;
    logic [AW:0]      pcnt;
    logic [AW-1:0]    k;
    logic [3:0]       n;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] best;
    logic [3:0]       best_idx;

    logic             x;
    logic [ACC_W-1:0] score;
    logic             take;

    assign state_o     = state;
    assign pix_wdata_o = pixel_i;

    assign x     = ~(pix_rdata_i ^ weight_i);
    assign score = acc + {{(ACC_W-1){1'b0}}, x};
    // Strict greater-than keeps the lower index on ties; neuron 0 always seeds the argmax.
    assign take  = (n == 4'd0) || (score > best);

    // mode_i is a level: every cycle it is high is one pixel offered on pixel_i, no stall.
    always_comb begin
        pix_we_o   = 1'b0;
        pix_addr_o = '0;
        case (state)
            IDLE, DONE: pix_we_o = mode_i;
            LOAD: begin
                pix_we_o   = mode_i && (pcnt < PCNT_FULL);
                pix_addr_o = pcnt[AW-1:0];
            end
            COMPUTE: begin
                pix_we_o   = mode_i;
                pix_addr_o = mode_i ? '0 : k;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pcnt     <= '0;
            k        <= '0;
            n        <= '0;
            acc      <= '0;
            best     <= '0;
            best_idx <= '0;
            answer_o <= '0;
            valid_o  <= 1'b0;
            busy_o   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (mode_i) begin
                        pcnt    <= (AW+1)'(1);
                        state   <= LOAD;
                        valid_o <= 1'b0;
                    end
                end
                LOAD: begin
                    if (mode_i) begin
                        if (pcnt < PCNT_FULL) pcnt <= pcnt + 1'b1;
                    end else if (pcnt == PCNT_FULL) begin
                        state    <= COMPUTE;
                        busy_o   <= 1'b1;
                        k        <= '0;
                        n        <= '0;
                        acc      <= '0;
                        best     <= '0;
                        best_idx <= '0;
                    end else begin
                        state <= IDLE;
                        pcnt  <= '0;
                    end
                end
                COMPUTE: begin
                    if (mode_i) begin
                        // Abort: this edge already wrote pixel 0, partial scores are dropped.
                        state   <= LOAD;
                        pcnt    <= (AW+1)'(1);
                        busy_o  <= 1'b0;
                        valid_o <= 1'b0;
                    end else if (k != K_LAST) begin
                        acc <= score;
                        k   <= k + 1'b1;
                    end else begin
                        if (take) begin
                            best     <= score;
                            best_idx <= n;
                        end
                        acc <= '0;
                        k   <= '0;
                        if (n == N_LAST) begin
                            state    <= DONE;
                            busy_o   <= 1'b0;
                            valid_o  <= 1'b1;
                            answer_o <= take ? n : best_idx;
                        end else begin
                            n <= n + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bnn_sequencer.sv
// Directed bench for bnn_sequencer: popcount/argmax model, per-cycle output compare,
// answer scoreboard and literal pins of the model.
module tb_bnn_sequencer;

    localparam int N_PIX  = 16;
    localparam int N_NEUR = 3;
    localparam int AW     = 4;
    localparam int ACC_W  = 5;
    localparam logic [15:0] IMG = 16'hA5C3;

    logic          clk = 1'b0;
    logic          rst;
    logic          mode_i, pixel_i, weight_i;
    logic          pix_we_o, pix_wdata_o, pix_rdata_i;
    logic [AW-1:0] pix_addr_o;
    logic [3:0]    answer_o;
    logic          valid_o, busy_o;
    logic [1:0]    state_o;

    bnn_sequencer #(.N_PIX(N_PIX), .N_NEUR(N_NEUR), .AW(AW), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst), .mode_i(mode_i), .pixel_i(pixel_i), .weight_i(weight_i),
        .pix_we_o(pix_we_o), .pix_addr_o(pix_addr_o), .pix_wdata_o(pix_wdata_o),
        .pix_rdata_i(pix_rdata_i), .answer_o(answer_o), .valid_o(valid_o),
        .busy_o(busy_o), .state_o(state_o)
    );

    // clock / reset block
    always #5 clk = ~clk;
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    // external pixel buffer
    logic pix_mem [N_PIX];
    always @(posedge clk) if (pix_we_o) pix_mem[pix_addr_o] <= pix_wdata_o;
    assign pix_rdata_i = pix_mem[pix_addr_o];

    int n_vec = 0;
    int n_bad = 0;

    logic          chk_en = 1'b0;
    logic          exp_we, exp_addr_chk, exp_busy, exp_valid;
    logic [AW-1:0] exp_addr;
    logic [3:0]    exp_answer;
    logic [3:0]    held_ans;
    logic          prev_valid = 1'b0;
    logic [3:0]    exp_q[$];

    task automatic check_val(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // model: XNOR popcount score and argmax with ties to the lower index
    function automatic int score_of(input logic [15:0] img, input logic [15:0] w);
        return $countones(~(img ^ w));
    endfunction

    function automatic logic [3:0] argmax(input logic [15:0] img, input logic [15:0] w0,
                                          input logic [15:0] w1, input logic [15:0] w2);
        int s [3];
        int top = -1;
        logic [3:0] idx = 4'd0;
        s = '{score_of(img, w0), score_of(img, w1), score_of(img, w2)};
        for (int i = 0; i < 3; i++) if (s[i] > top) begin top = s[i]; idx = 4'(i); end
        return idx;
    endfunction

    // compare process
    always @(negedge clk) begin
        if (chk_en) begin
            check_val("pix_we", pix_we_o, exp_we);
            if (exp_we || exp_addr_chk) check_val("pix_addr", pix_addr_o, exp_addr);
            if (exp_we) check_val("pix_wdata", pix_wdata_o, pixel_i);
            check_val("busy", busy_o, exp_busy);
            check_val("valid", valid_o, exp_valid);
            check_val("answer", answer_o, exp_answer);
            if (valid_o && !prev_valid) begin
                if (exp_q.size() == 0) check_val("sb_unexpected_valid", 1, 0);
                else check_val("sb_answer", answer_o, exp_q.pop_front());
            end
            prev_valid <= valid_o;
        end
    end

    // driver tasks
    task automatic cyc(input logic m, input logic p, input logic w, input logic we,
                       input logic achk, input logic [AW-1:0] a, input logic nb,
                       input logic nv, input logic [3:0] na);
        mode_i = m; pixel_i = p; weight_i = w;
        exp_we = we; exp_addr_chk = achk; exp_addr = a;
        @(posedge clk); #1;
        exp_busy = nb; exp_valid = nv; exp_answer = na;
    endtask

    task automatic load_pixels(input logic [15:0] img, input int start, input int ncyc);
        for (int i = start; i < start + ncyc; i++) begin
            logic inr = (i < N_PIX);
            logic pb  = inr ? img[i[3:0]] : 1'($urandom_range(0, 1));
            cyc(1'b1, pb, 1'($urandom_range(0, 1)), inr, inr, AW'(inr ? i : 0),
                1'b0, 1'b0, held_ans);
        end
    endtask

    task automatic compute(input logic [15:0] img, input logic [15:0] w0,
                           input logic [15:0] w1, input logic [15:0] w2, input int abort_at);
        logic [15:0] wv [3];
        logic [3:0] ans;
        wv = '{w0, w1, w2};
        ans = argmax(img, w0, w1, w2);
        if (abort_at == 0) exp_q.push_back(ans);
        cyc(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0, '0, 1'b1, 1'b0, held_ans);
        for (int j = 0; j < N_PIX * N_NEUR; j++) begin
            int kk = j % N_PIX;
            int nn = j / N_PIX;
            logic last = (j == N_PIX * N_NEUR - 1);
            if (j + 1 == abort_at) begin
                cyc(1'b1, img[0], 1'($urandom_range(0, 1)), 1'b1, 1'b1, '0, 1'b0, 1'b0, held_ans);
                return;
            end
            if (last) held_ans = ans;
            cyc(1'b0, 1'($urandom_range(0, 1)), wv[nn][kk[3:0]], 1'b0, 1'b1, AW'(kk),
                !last, last, held_ans);
        end
    endtask

    initial begin
        rst = 1'b1; mode_i = 1'b0; pixel_i = 1'b0; weight_i = 1'b0;
        held_ans = 4'd0;
        for (int i = 0; i < N_PIX; i++) pix_mem[i] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_answer", answer_o, 0);
        check_val("rst_valid", valid_o, 0);
        check_val("rst_busy", busy_o, 0);
        check_val("rst_we", pix_we_o, 0);
        check_val("rst_addr", pix_addr_o, 0);
        check_val("rst_state", state_o, 0);
        rst = 1'b0;
        exp_busy = 1'b0; exp_valid = 1'b0; exp_answer = 4'd0;
        exp_we = 1'b0; exp_addr_chk = 1'b1; exp_addr = '0;
        chk_en = 1'b1;
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0, 1'b0, 1'b0, 4'd0);

        // model pins, hand computed
        check_val("pin_score_n0", score_of(IMG, ~IMG), 0);
        check_val("pin_score_n1", score_of(IMG, IMG), 16);
        check_val("pin_score_n2", score_of(IMG, IMG ^ 16'h0007), 13);
        check_val("pin_argmax", argmax(IMG, ~IMG, IMG, IMG ^ 16'h0007), 1);
        check_val("pin_tie_n1", score_of(IMG, IMG ^ 16'h07FF), 5);
        check_val("pin_tie_argmax", argmax(IMG, IMG ^ 16'h000F, IMG ^ 16'h07FF, IMG ^ 16'hF000), 0);

        // full classify, then DONE holds
        load_pixels(IMG, 0, 16);
        compute(IMG, ~IMG, IMG, IMG ^ 16'h0007, 0);
        check_val("classify_answer", answer_o, 1);
        check_val("classify_valid", valid_o, 1);
        repeat (3) cyc(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'b0, 1'b0, '0, 1'b0, 1'b1, held_ans);

        // tie keeps the lower index
        load_pixels(IMG, 0, 16);
        compute(IMG, IMG ^ 16'h000F, IMG ^ 16'h07FF, IMG ^ 16'hF000, 0);
        check_val("tie_answer", answer_o, 0);

        // short load returns to IDLE
        load_pixels(IMG, 0, 10);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, held_ans);
        repeat (4) cyc(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b1, '0, 1'b0, 1'b0, held_ans);
        check_val("short_state", state_o, 0);

        // over-load saturates at 16 writes
        load_pixels(IMG, 0, 20);
        compute(IMG, ~IMG, IMG, IMG ^ 16'h0007, 0);
        check_val("overload_answer", answer_o, 1);

        // abort at compute edge 20, then reload and finish
        load_pixels(IMG, 0, 16);
        compute(IMG, IMG ^ 16'h000F, IMG ^ 16'h07FF, IMG ^ 16'hF000, 20);
        check_val("abort_busy", busy_o, 0);
        check_val("abort_answer_held", answer_o, 1);
        check_val("abort_state", state_o, 1);
        load_pixels(IMG, 1, 15);
        compute(IMG, IMG ^ 16'h000F, IMG ^ 16'h07FF, IMG ^ 16'hF000, 0);
        check_val("reload_answer", answer_o, 0);

        // reset mid-compute
        load_pixels(IMG, 0, 16);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, held_ans);
        for (int j = 0; j < 10; j++)
            cyc(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b1, AW'(j), 1'b1, 1'b0, held_ans);
        rst = 1'b1;
        held_ans = 4'd0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, held_ans);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0, 1'b0, 1'b0, held_ans);
        check_val("midrst_state", state_o, 0);
        check_val("midrst_answer", answer_o, 0);
        rst = 1'b0;
        repeat (5) cyc(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'b0, 1'b1, '0, 1'b0, 1'b0, held_ans);
        check_val("midrst_state_after", state_o, 0);

        check_val("sb_exp_q_empty", exp_q.size(), 0);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/bnn_sequencer.md
# bnn_sequencer

Control sequencer for the MNIST binary neural network inside `tt_um_mnist_bnn`. It turns the serial pin protocol (`mode`, `pixel_in`, `weight_in`) into pixel-buffer write and read cycles. It runs the XNOR-popcount accumulation for every output neuron and tracks the running argmax. It presents the classified digit on the answer nibble that drives `uo_out[3:0]`.

## Interface

Parameters:
- `N_PIX`, 784: binarised input pixels per image.
- `N_NEUR`, 10: output neurons (digit classes), at most 16.
- `AW`, 10: pixel address width, equal to clog2(N_PIX).
- `ACC_W`, 10: score width, equal to clog2(N_PIX+1).

Ports:
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `mode_i`  in  1  1 = load pixels, 0 = compute/hold (`ui_in[0]`).
- `pixel_i`  in  1  serial pixel bit (`ui_in[1]`).
- `weight_i`  in  1  serial weight bit, neuron-major then pixel order (`ui_in[2]`).
- `pix_we_o`  out  1  pixel buffer write enable.
- `pix_addr_o`  out  AW  pixel buffer address, used for both write and read.
- `pix_wdata_o`  out  1  pixel buffer write data, equal to `pixel_i`.
- `pix_rdata_i`  in  1  pixel buffer read data, combinational from `pix_addr_o`.
- `answer_o`  out  4  winning neuron index (drives `uo_out[3:0]`).
- `valid_o`  out  1  `answer_o` holds a result for the most recent full image.
- `busy_o`  out  1  high while in COMPUTE.

## Operation

States: IDLE, LOAD, COMPUTE, DONE. Internal counters:
- `pcnt`: 0..N_PIX, load count.
- `k`: 0..N_PIX-1, pixel index during compute.
- `n`: 0..N_NEUR-1, neuron index.
- `acc`: ACC_W bits, running score.
- `best`: ACC_W bits, best score so far.
- `best_idx`: 4 bits, index of `best`.

Load phase:
- IDLE, LOAD or DONE with `mode_i`=1 and `pcnt`<N_PIX:
  - `pix_we_o`=1, `pix_addr_o`=`pcnt`.
  - On the edge: `pcnt`+=1, state to LOAD, `valid_o` to 0.
- IDLE or DONE with `mode_i`=1 first clears `pcnt` to 0, so the written address is 0.
- LOAD with `mode_i`=1 and `pcnt`=N_PIX: saturate. No write, extra bits are discarded.
- LOAD with `mode_i`=0:
  - If `pcnt`=N_PIX: go to COMPUTE. Set `k`=0, `n`=0, `acc`=0, `best`=0, `best_idx`=0. The `weight_i` on this edge is not consumed.
  - If `pcnt`<N_PIX (short load): go to IDLE, `pcnt` to 0, no result.

Compute phase:
- `pix_addr_o`=`k`, `pix_we_o`=0, `busy_o`=1.
- Each edge consumes one weight bit. Let `x` = ~(`pix_rdata_i` ^ `weight_i`).
  - If `k`<N_PIX-1: `acc`+=`x`, `k`+=1.
  - If `k`=N_PIX-1: final score `s` = `acc`+`x`.
    - If `s`>`best`, or `n`=0, then `best`=`s` and `best_idx`=`n`.
    - Ties keep the lower index.
    - Then `acc`=0, `k`=0, `n`+=1.
- The last bit of neuron N_NEUR-1 commits the argmax. State goes to DONE, `valid_o`=1 and `answer_o`=final `best_idx`.
- `mode_i`=1 during COMPUTE aborts the run:
  - That edge writes pixel 0, sets `pcnt`=1 and enters LOAD.
  - Accumulation is discarded, and `answer_o`/`valid_o` are not updated from the partial run.

DONE:
- Holds `answer_o` and `valid_o`, ignores `weight_i`.
- Exits only on `mode_i`=1, which starts a new load.

Arithmetic:
- `acc` cannot overflow because its maximum is N_PIX.
- The comparison is unsigned, at ACC_W bits.

## Timing

- Reset values: state IDLE; `pcnt`, `k`, `n`, `acc`, `best` and `best_idx` all 0; `answer_o`=0, `valid_o`=0, `busy_o`=0, `pix_we_o`=0, `pix_addr_o`=0.
- `rst` overrides everything, including mid-load and mid-compute.
- Output decode:
  - `pix_we_o`, `pix_addr_o` and `pix_wdata_o` are combinational from state, counters and `mode_i`.
  - `answer_o`, `valid_o` and `busy_o` are registered.
- Load: one pixel per cycle, N_PIX cycles.
- Compute latency: `valid_o` rises on the edge that consumes weight bit N_PIX×N_NEUR, counted from the first COMPUTE edge. That is N_PIX×N_NEUR+1 edges after the mode falling edge is sampled (7841 for the defaults).
- `valid_o` falls on the first edge that samples `mode_i`=1.

## Test plan

All scenarios use N_PIX=16, N_NEUR=3, AW=4, ACC_W=5.

1. Reset check:
   - Stimulus: assert `rst` for 2 cycles mid-COMPUTE.
   - Required: all outputs 0, state IDLE. With `mode_i`=0 afterwards, no writes occur and `valid_o` stays 0.
2. Full classify:
   - Stimulus: load pixels 0xA5C3 (LSB first). Weights: neuron0 = ~pixels, neuron1 = pixels, neuron2 = pixels with 3 bits flipped.
   - Required: scores 0/16/13, `answer_o`=1, `valid_o`=1 exactly 49 edges after mode falls.
3. Tie:
   - Stimulus: neurons 0 and 2 both score 12, neuron 1 scores 5.
   - Required: `answer_o`=0.
4. Short load:
   - Stimulus: `mode_i`=1 for 10 cycles, then 0.
   - Required: state returns to IDLE, `busy_o` never asserts, `valid_o` stays 0.
5. Over-load:
   - Stimulus: `mode_i`=1 for 20 cycles.
   - Required: `pix_we_o` high for exactly 16 cycles with addresses 0..15, then the result matches scenario 2.
6. Abort:
   - Stimulus: raise `mode_i` at compute edge 20.
   - Required: `busy_o` falls, pixel written at address 0, previous `valid_o`/`answer_o` are not overwritten with the partial result, and the reloaded run yields the correct answer.
